// File: rtl/wb_arbiter_buf.sv
// Writeback collection stage: per-FU 2-entry FIFOs feeding up to NUM_WRITE register-file
// write ports per cycle, round-robin, never two writes to the same address in one cycle.
module wb_arbiter_buf #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned NUM_FU    = 4,
    parameter int unsigned NUM_WRITE = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_FU-1:0]         FU_VALID,
    output logic [NUM_FU-1:0]         FU_READY,
    input  logic [AW*NUM_FU-1:0]      FU_WADDR,
    input  logic [DW*NUM_FU-1:0]      FU_WDATA,
    input  logic                      STALL,
    output logic [NUM_WRITE-1:0]      WE,
    output logic [AW*NUM_WRITE-1:0]   WADDR,
    output logic [DW*NUM_WRITE-1:0]   WDATA,
    output logic                      BUSY
);
    localparam int unsigned PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [1:0]           cnt_q      [NUM_FU];
    logic [NUM_FU-1:0]    rd_q;
    logic [AW-1:0]        mem_addr_q [NUM_FU][2];
    logic [DW-1:0]        mem_data_q [NUM_FU][2];
    logic [AW-1:0]        head_addr  [NUM_FU];
    logic [DW-1:0]        head_data  [NUM_FU];
    logic [NUM_FU-1:0]    wr_idx;
    logic [NUM_FU-1:0]    push;
    logic [NUM_FU-1:0]    pop;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NUM_WRITE-1:0]    gnt_we;
    logic [AW*NUM_WRITE-1:0] gnt_addr;
    logic [DW*NUM_WRITE-1:0] gnt_data;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            head_addr[i] = mem_addr_q[i][rd_q[i]];
            head_data[i] = mem_data_q[i][rd_q[i]];
            // Next free slot sits one past the head when a single entry is held.
            wr_idx[i]    = rd_q[i] ^ cnt_q[i][0];
            FU_READY[i]  = RST && (cnt_q[i] != 2'd2);
        end
        push = FU_VALID & FU_READY;
    end

    always_comb begin
        int          n;
        int          kint;
        logic [PW-1:0] k;
        logic [PW-1:0] last;
        logic        hit;
        logic        any;
        pop      = '0;
        gnt_we   = '0;
        gnt_addr = '0;
        gnt_data = '0;
        n        = 0;
        kint     = 0;
        k        = '0;
        hit      = 1'b0;
        any      = 1'b0;
        last     = ptr_q;
        for (int j = 0; j < NUM_FU; j++) begin
            kint = int'(ptr_q) + j;
            if (kint >= int'(NUM_FU)) kint = kint - int'(NUM_FU);
            k = PW'(kint);
            if (!STALL && cnt_q[k] != 2'd0 && n < int'(NUM_WRITE)) begin
                hit = 1'b0;
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (p < n && gnt_addr[p*AW +: AW] == head_addr[k]) hit = 1'b1;
                end
                if (!hit) begin
                    for (int p = 0; p < NUM_WRITE; p++) begin
                        if (p == n) begin
                            gnt_we[p]            = 1'b1;
                            gnt_addr[p*AW +: AW] = head_addr[k];
                            gnt_data[p*DW +: DW] = head_data[k];
                        end
                    end
                    pop[k] = 1'b1;
                    n      = n + 1;
                    last   = k;
                    any    = 1'b1;
                end
            end
        end
        ptr_d = ptr_q;
        if (any) ptr_d = (last == PW'(NUM_FU - 1)) ? '0 : last + PW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ptr_q <= '0;
            rd_q  <= '0;
            WE    <= '0;
            WADDR <= '0;
            WDATA <= '0;
            for (int i = 0; i < NUM_FU; i++) cnt_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            WE    <= gnt_we;
            WADDR <= gnt_addr;
            WDATA <= gnt_data;
            for (int i = 0; i < NUM_FU; i++) begin
                if (pop[i]) rd_q[i] <= ~rd_q[i];
                cnt_q[i] <= cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
        end
    end

    // Storage needs no reset: counts gate every read.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem_addr_q[i][wr_idx[i]] <= FU_WADDR[i*AW +: AW];
                mem_data_q[i][wr_idx[i]] <= FU_WDATA[i*DW +: DW];
            end
        end
    end

    always_comb begin
        BUSY = |WE;
        for (int i = 0; i < NUM_FU; i++) BUSY = BUSY | (cnt_q[i] != 2'd0);
    end

endmodule

// File: doc/wb_arbiter_buf.md
Name: wb_arbiter_buf

Overview:
- Writeback collection stage that sits directly upstream of the multi-write-port register file.
- Accepts results from NUM_FU functional units through valid/ready handshakes and buffers each unit in a 2-entry FIFO.
- Each cycle it grants up to NUM_WRITE FIFO heads round-robin and drives registered WE/WADDR/WDATA straight into the register file's write ports.
- It never issues two writes to the same address in one cycle, so the register file's write-port priority is never exercised.

Parameters:
- DW, 32: data width of one register.
- AW, 5: register address width.
- NUM_FU, 4: number of producer functional units (at least 2).
- NUM_WRITE, 2: number of register-file write ports driven (1 to NUM_FU).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; synchronous, active-low.
- FU_VALID  input  NUM_FU  producer i presents a result.
- FU_READY  output  NUM_FU  FIFO i can accept; a function of state only.
- FU_WADDR  input  AW*NUM_FU  destination address of producer i, slice [i*AW +: AW].
- FU_WDATA  input  DW*NUM_FU  result data of producer i, slice [i*DW +: DW].
- STALL  input  1  suppresses all grants this cycle.
- WE  output  NUM_WRITE  write enable per port, registered.
- WADDR  output  AW*NUM_WRITE  write address per port, registered.
- WDATA  output  DW*NUM_WRITE  write data per port, registered.
- BUSY  output  1  any FIFO non-empty or any WE bit set.

Behaviour:
- Reset, applied when RST is low at a clock edge, clears everything:
  - all FIFO counts to 0;
  - round-robin pointer to 0;
  - WE, WADDR and WDATA to 0;
  - FU_READY forced to all-0 while RST is low;
  - BUSY to 0.
- Reset mid-operation discards all buffered entries and any pending WE. Nothing is written after reset.
- FIFO i (depth 2):
  - Push on FU_VALID[i] & FU_READY[i].
  - FU_READY[i] = (count_i < 2) when not in reset.
  - Push and pop in the same cycle are allowed, and count is unchanged.
  - A pop when full is allowed; FU_READY rises the next cycle.
  - Order within one FU is preserved.
- Grant selection (combinational on the current FIFO state):
  - Scan FUs starting at the pointer, wrapping modulo NUM_FU.
  - FU k is granted if its FIFO is non-empty, fewer than NUM_WRITE grants are already made, and its head address differs from every address already granted this cycle.
  - Grants map to write ports in scan order; the first grant goes to port 0.
- Conflict: an FU whose head address matches an earlier grant is skipped. It stays at its head and retries next cycle.
- STALL=1: no grants and no pops. WE is 0 in the following cycle; the pointer holds.
- Registered outputs:
  - At the edge, port p loads WE[p] = 1 with the head address and data of its granted FU, and that FIFO pops.
  - Ungranted ports load WE[p] = 0. WADDR/WDATA of an ungranted port are don't-care; the implementation drives them to 0.
- Pointer update: if at least one grant was made, the pointer becomes (index of last granted FU + 1) mod NUM_FU. Otherwise it holds.
- Latency:
  - Handshake at edge E0: the entry is in the FIFO after E0.
  - If granted, WE is high after E1.
  - The register file is updated at E2.
  - Minimum 2 cycles from handshake to WE; no combinational path from FU inputs to WE/WADDR/WDATA.
- Throughput: up to NUM_WRITE writes per cycle. A single FU sustains 1 per cycle (push and pop every cycle).
- BUSY is computed from registered state only.

Test Plan:
- Single write: after reset, FU0 drives addr=3, data=0xDEADBEEF for one cycle -> WE=2'b01, WADDR port0=3, WDATA port0=0xDEADBEEF exactly 2 cycles later, for one cycle. BUSY falls the cycle after.
- Port fill and round-robin: all 4 FUs push distinct addrs 1..4 in the same cycle, pointer=0 -> FU0,FU1 granted on ports 0,1. Next cycle FU2,FU3 granted. Pointer returns to 0.
- Address conflict: FU1 and FU2 both push addr=7 (data 0x11, 0x22), pointer=0 -> only FU1 is written in the first grant cycle (WE=2'b01). FU2 is written the next cycle. Same-address WE is never seen on two ports in one cycle.
- Backpressure: FU0 pushes 3 back-to-back results with STALL=1 -> FU_READY[0] drops after 2 accepts. Release STALL -> results emerge in order on consecutive cycles, and READY returns high one cycle after the first pop.
- STALL and pointer: with pending entries in all FIFOs, hold STALL=1 for 3 cycles -> WE=0 throughout, pointer unchanged. On release, grants resume from the same pointer.
- Reset mid-operation: fill FIFOs of FU0 and FU2, assert RST low for 1 cycle -> WE=0, FU_READY=0 during reset, BUSY=0 after. No stale write ever appears.
